// File: rtl/video_mem_arbiter_pkg.sv
// video_mem_arbiter_pkg
//   Shared definitions for the video memory arbiter. It holds the slot
//   numbers inside an 8-clock character cell, the CPU port state
//   encoding and the cell width in pixels.
package video_mem_arbiter_pkg;

  localparam int CHAR_PIXELS = 8;
  localparam int SLOT_WIDTH  = $clog2(CHAR_PIXELS);

  typedef logic [SLOT_WIDTH-1:0] slot_t;

  localparam slot_t SLOT_VRAM  = slot_t'(0);  // video owns the RAM port
  localparam slot_t SLOT_CODE  = slot_t'(1);  // character code returns from VRAM
  localparam slot_t SLOT_ROM   = slot_t'(2);  // char ROM address presented
  localparam slot_t SLOT_GLYPH = slot_t'(3);  // glyph byte returns from ROM
  localparam slot_t SLOT_LOAD  = slot_t'(7);  // shifter load strobe

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2,
    ACK    = 2'd3
  } cpu_state_t;

endpackage

// File: rtl/vram_cpu_port.sv
// vram_cpu_port
//   CPU side of the VRAM time-slot arbiter. It decides when a CPU access
//   may take the RAM port, captures read data and produces the ack pulse.
//   The top module owns the RAM port registers and loads them on
//   access_start.
//
//   state  | meaning
//   IDLE   | waiting for cpu_req
//   ACCESS | CPU address/we/wdata on the RAM port for one cycle
//   RDATA  | RAM read data valid; captured for reads
//   ACK    | cpu_ack high; a still-held request chains straight into ACCESS
//
// Ports
//   clk, reset    pixel clock, async active-high reset
//   cpu_req       request, held until cpu_ack
//   cpu_we        1 = write
//   slot0_next    the next cycle is slot 0, which belongs to video
//   ram_rdata     VRAM synchronous read data
//   access_start  combinational: RAM port goes to the CPU on this edge
//   cpu_ack       1-cycle completion pulse (registered)
//   cpu_rdata     read data, held until the next read completes
module vram_cpu_port
  import video_mem_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_we,
  input  logic       slot0_next,
  input  logic [7:0] ram_rdata,
  output logic       access_start,
  output logic       cpu_ack,
  output logic [7:0] cpu_rdata
);

  cpu_state_t state_q;
  logic       we_q;

  // Slot 0 is never granted, so a request arriving just before it waits one cycle.
  assign access_start = cpu_req && !slot0_next &&
                        ((state_q == IDLE) || (state_q == ACK));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= 8'h00;
    end else begin
      cpu_ack <= 1'b0;
      case (state_q)
        IDLE: begin
          if (access_start) begin
            state_q <= ACCESS;
            we_q    <= cpu_we;
          end
        end
        ACCESS: state_q <= RDATA;
        RDATA: begin
          if (!we_q) cpu_rdata <= ram_rdata;
          cpu_ack <= 1'b1;
          state_q <= ACK;
        end
        ACK: begin
          if (access_start) begin
            state_q <= ACCESS;
            we_q    <= cpu_we;
          end else begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/video_mem_arbiter.sv
// video_mem_arbiter
//   Shares the single-port VRAM between display fetch and the CPU on an
//   8-slot character cell, runs the char-ROM lookup and hands one glyph
//   byte per cell to the pixel shifter.
//
// Ports
//   clk, reset                  16 MHz pixel clock, async active-high reset
//   char_start                  pulse in the cycle before a cell's slot 0
//   video_active, ma, ra        cell timing/address from the CRTC
//   charset                     char ROM bank select
//   cpu_req/we/addr/wdata       CPU access request (held until cpu_ack)
//   cpu_ack, cpu_rdata          CPU completion pulse and read data
//   ram_addr/we/wdata/rdata     VRAM port (outputs registered)
//   rom_addr, rom_rdata         char ROM port (address registered)
//   pixel_data/invert/load      glyph byte, reverse-video bit, load strobe
module video_mem_arbiter
  import video_mem_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = 11,
  parameter int RA_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  char_start,
  input  logic                  video_active,
  input  logic [ADDR_WIDTH-1:0] ma,
  input  logic [RA_WIDTH-1:0]   ra,
  input  logic                  charset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [7:0]            cpu_wdata,
  output logic                  cpu_ack,
  output logic [7:0]            cpu_rdata,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [7:0]            ram_wdata,
  input  logic [7:0]            ram_rdata,
  output logic [RA_WIDTH+7:0]   rom_addr,
  input  logic [7:0]            rom_rdata,
  output logic [7:0]            pixel_data,
  output logic                  pixel_invert,
  output logic                  pixel_load
);

  slot_t               slot_q;
  slot_t               next_slot;
  logic                cpu_start;
  logic [RA_WIDTH-1:0] ra_s;
  logic                charset_s;
  logic                active_s;
  logic [7:0]          code_q;
  logic [7:0]          glyph_q;

  // char_start forces a cell boundary, truncating the current cell.
  assign next_slot = char_start ? SLOT_VRAM : slot_t'(slot_q + slot_t'(1));

  vram_cpu_port u_cpu_port (
    .clk          (clk),
    .reset        (reset),
    .cpu_req      (cpu_req),
    .cpu_we       (cpu_we),
    .slot0_next   (next_slot == SLOT_VRAM),
    .ram_rdata    (ram_rdata),
    .access_start (cpu_start),
    .cpu_ack      (cpu_ack),
    .cpu_rdata    (cpu_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q       <= SLOT_VRAM;
      ram_addr     <= '0;
      ram_we       <= 1'b0;
      ram_wdata    <= 8'h00;
      rom_addr     <= '0;
      ra_s         <= '0;
      charset_s    <= 1'b0;
      active_s     <= 1'b0;
      code_q       <= 8'h00;
      glyph_q      <= 8'h00;
      pixel_data   <= 8'h00;
      pixel_invert <= 1'b0;
      pixel_load   <= 1'b0;
    end else begin
      slot_q <= next_slot;
      ram_we <= 1'b0;

      // RAM port: video in slot 0, CPU in its single ACCESS cycle,
      // otherwise the address just holds.
      if (next_slot == SLOT_VRAM) begin
        ram_addr  <= ma;
        ra_s      <= ra;
        charset_s <= charset;
        active_s  <= video_active;
      end else if (cpu_start) begin
        ram_addr  <= cpu_addr;
        ram_we    <= cpu_we;
        ram_wdata <= cpu_wdata;
      end

      // The ROM address is built from the code byte as it arrives, so the
      // lookup is on the ROM port during slot 2.
      if (slot_q == SLOT_CODE) begin
        code_q   <= ram_rdata;
        rom_addr <= {charset_s, ram_rdata[6:0], ra_s};
      end

      if (slot_q == SLOT_GLYPH) glyph_q <= rom_rdata;

      // Only a cell that actually reaches slot 7 loads the shifter.
      pixel_load <= (next_slot == SLOT_LOAD);
      if (next_slot == SLOT_LOAD) begin
        pixel_data   <= active_s ? glyph_q : 8'h00;
        pixel_invert <= active_s & code_q[7];
      end
    end
  end

endmodule
